// File: rtl/micro_core.sv
// Multi-cycle execution core: register file, ALU and a fetch/decode/execute/writeback
// controller behind a valid/ready instruction port, with status flags and a debug read port.
module micro_core #(
  parameter int unsigned  DATA_W    = 4,
  parameter int unsigned  NREG      = 4,
  parameter bit           WB_ON_OVF = 1'b0,
  localparam int unsigned RA_W      = $clog2(NREG),
  localparam int unsigned INSTR_W   = 4 + 3 * RA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               ovf,
  output logic               ovf_sticky,
  input  logic               clr_ovf,
  output logic               zero,
  output logic               neg,
  output logic               illegal,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_EXECUTE = 2'd2;
  localparam logic [1:0] S_WB      = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic rv_q, rv_d, ill_q, ill_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic sticky_q, sticky_d, wr_q, wr_d, ready_q, ready_d;

  logic [3:0]        opcode;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0] sum, diff, imm_sum, imm_rs2, imm_ldi, alu_res;
  logic              alu_ovf, arith, produces, writes, illegal_op, ovf_set;

  assign opcode  = instr_q[INSTR_W-1 -: 4];
  assign rd      = instr_q[3*RA_W-1 -: RA_W];
  assign rs1     = instr_q[2*RA_W-1 -: RA_W];
  assign rs2     = instr_q[RA_W-1:0];
  assign imm_rs2 = DATA_W'(rs2);
  assign imm_ldi = DATA_W'({rs1, rs2});

  // ALU on the operands latched in DECODE
  always_comb begin
    sum        = a_q + b_q;
    diff       = a_q - b_q;
    imm_sum    = a_q + imm_rs2;
    alu_res    = '0;
    alu_ovf    = 1'b0;
    arith      = 1'b0;
    produces   = 1'b1;
    writes     = 1'b1;
    illegal_op = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum;
        arith   = 1'b1;
        alu_ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        arith   = 1'b1;
        alu_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: alu_res = {a_q[MSB-1:0], 1'b0};
      OP_SHR: alu_res = {1'b0, a_q[MSB:1]};
      OP_LDI: alu_res = imm_ldi;
      OP_MOV: alu_res = a_q;
      OP_ADDI: begin
        alu_res = imm_sum;
        arith   = 1'b1;
        alu_ovf = (a_q[MSB] == imm_rs2[MSB]) && (imm_sum[MSB] != a_q[MSB]);
      end
      OP_CMP: begin
        alu_res = diff;
        writes  = 1'b0;
        alu_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_NOP: begin
        produces = 1'b0;
        writes   = 1'b0;
      end
      default: begin
        produces   = 1'b0;
        writes     = 1'b0;
        illegal_op = 1'b1;
      end
    endcase
  end

  // Sequencer; outputs are loaded at the end of EXECUTE so they are visible during WRITEBACK
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    wr_d     = wr_q;
    rv_d     = 1'b0;
    ill_d    = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rs1];
        b_d     = regs_q[rs2];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_WB;
        rv_d    = produces;
        ill_d   = illegal_op;
        wr_d    = writes && !(arith && alu_ovf && !WB_ON_OVF);
        if (produces) begin
          result_d = alu_res;
          ovf_d    = alu_ovf;
          zero_d   = (alu_res == '0);
          neg_d    = alu_res[MSB];
          ovf_set  = alu_ovf;
        end
      end
      default: begin
        state_d = S_IDLE;
        // keeps a clear raised during the writeback cycle from undoing the set
        ovf_set = rv_q && ovf_q;
      end
    endcase
    sticky_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : sticky_q);
    ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      ill_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      sticky_q <= 1'b0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      ill_q    <= ill_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      sticky_q <= sticky_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
    end
  end

  // Register file write at the end of WRITEBACK
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB && wr_q) begin
      regs_q[rd] <= result_q;
    end
  end

  assign instr_ready  = ready_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign ovf          = ovf_q;
  assign ovf_sticky   = sticky_q;
  assign zero         = zero_q;
  assign neg          = neg_q;
  assign illegal      = ill_q;
  assign dbg_data     = regs_q[dbg_addr];

endmodule
